// File: rtl/mux_scan_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_scan_collector: steps an external 8:1 mux and assembles its bits     |
// | into one word, handed off with a valid/ready handshake.  Rev 1.0         |
// +--------------------------------------------------------------------------+
module mux_scan_collector #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       y_in,
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_sel, w_sel_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_word, w_word_nxt;
  logic       r_valid, w_valid_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= 3'd0;
      r_cnt   <= 4'd0;
      r_word  <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_word  <= w_word_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_word_nxt  = r_word;
    w_valid_nxt = r_valid;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SCAN;
          w_sel_nxt   = 3'd0;
          w_cnt_nxt   = 4'd0;
        end
      end
      SCAN: begin
        if (r_cnt == SETTLE_LAST) begin
          // Last settle cycle: capture this channel, then advance or finish.
          w_word_nxt[r_sel] = y_in;
          w_cnt_nxt         = 4'd0;
          if (r_sel == 3'd7) begin
            w_state_nxt = HOLD;
            w_valid_nxt = 1'b1;
          end else begin
            w_sel_nxt = r_sel + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      HOLD: begin
        if (r_valid && out_ready) begin
          w_valid_nxt = 1'b0;
          w_sel_nxt   = 3'd0;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = cont ? SCAN : IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_sel_nxt   = 3'd0;
        w_cnt_nxt   = 4'd0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign sel       = r_sel;
  assign out_data  = r_word;
  assign out_valid = r_valid;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mux_scan_collector: randomized scans checked by a queue scoreboard.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mux_scan_collector;

  localparam int SETTLE = 3;
  localparam int LAT    = 8 * SETTLE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       out_ready = 1'b0;
  logic       y_in;
  logic [2:0] sel;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic [7:0] pattern = 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected word plus the edge at which its scan began.
  typedef struct {
    logic [7:0] word;
    int         k;
  } exp_t;
  exp_t exp_q[$];

  mux_scan_collector #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .y_in(y_in),
    .out_ready(out_ready), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .busy(busy)
  );

  // Downstream mux returns the selected bit of the current pattern.
  assign y_in = pattern[sel];

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    logic       rst_s, hs, prev_valid;
    logic [7:0] held;
    exp_t       e;
    prev_valid = 1'b0;
    held       = 8'h00;
    forever begin
      @(posedge clk);
      cyc++;
      rst_s = rst;
      hs    = out_valid && out_ready;
      #1;
      if (rst_s) begin
        chk("rst_sel", int'(sel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
      end else begin
        if (prev_valid && hs) chk("hs_valid_clear", int'(out_valid), 0);
        if (out_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("word", int'(out_data), int'(e.word));
            chk("latency", cyc - e.k, LAT);
            chk("hold_sel", int'(sel), 7);
          end
        end else if (out_valid) begin
          chk("hold_stable", int'(out_data), int'(held));
          chk("hold_sel", int'(sel), 7);
          chk("hold_busy", int'(busy), 1);
        end else if (exp_q.size() != 0 && cyc >= exp_q[0].k) begin
          if (cyc - exp_q[0].k < LAT) begin
            chk("scan_sel", int'(sel), (cyc - exp_q[0].k) / SETTLE);
            chk("scan_busy", int'(busy), 1);
          end else begin
            chk("valid_late", int'(out_valid), 1);
          end
        end else if (exp_q.size() == 0) begin
          chk("idle_busy", int'(busy), 0);
          chk("idle_sel", int'(sel), 0);
        end
      end
      prev_valid = out_valid;
      held       = out_data;
    end
  end

  task automatic issue_start(input logic [7:0] p);
    pattern = p;
    start   = 1'b1;
    exp_q.push_back('{word: p, k: cyc + 1});
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for out_valid while randomly toggling don't-care inputs.
  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 200) begin
      out_ready = 1'($urandom);
      cont      = 1'($urandom);
      start     = 1'($urandom);
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    start     = 1'b0;
    chk("wait_valid_timeout", int'(out_valid), 1);
  endtask

  task automatic hold_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      out_ready = 1'b0;
      cont      = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic handshake(input logic c, input logic [7:0] np);
    out_ready = 1'b1;
    cont      = c;
    if (c) begin
      pattern = np;
      exp_q.push_back('{word: np, k: cyc + 1});
    end
    @(negedge clk);
    out_ready = 1'b0;
    cont      = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : stimulus
    logic       c;
    int         chain;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic word, held for 5 cycles, then released to IDLE.
    issue_start(8'hA5);
    wait_valid();
    hold_cycles(5);
    handshake(1'b0, 8'h00);
    repeat (2) @(negedge clk);

    // Back-to-back continuous scans with a new pattern.
    issue_start(8'h3C);
    wait_valid();
    handshake(1'b1, 8'h5A);
    wait_valid();
    handshake(1'b0, 8'h00);
    @(negedge clk);

    // Start during SCAN at sel=4 is ignored.
    issue_start(8'hC3);
    repeat (4 * SETTLE) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid();
    handshake(1'b0, 8'h00);

    // Reset at sel=5 aborts; next scan is clean.
    issue_start(8'hFF);
    repeat (5 * SETTLE) @(negedge clk);
    pulse_rst();
    @(negedge clk);
    issue_start(8'h81);
    wait_valid();
    handshake(1'b0, 8'h00);

    // Reset in HOLD wins over a simultaneous handshake.
    issue_start(8'h7E);
    wait_valid();
    hold_cycles(2);
    out_ready = 1'b1;
    cont      = 1'b1;
    pulse_rst();
    out_ready = 1'b0;
    cont      = 1'b0;
    repeat (2) @(negedge clk);

    // Reset wins over start.
    start = 1'b1;
    pulse_rst();
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Randomized scans with random hold lengths and cont chains.
    for (int i = 0; i < 8; i++) begin
      issue_start(8'($urandom));
      wait_valid();
      chain = 0;
      do begin
        hold_cycles(int'($urandom_range(0, 4)));
        c = (chain < 3) ? 1'($urandom) : 1'b0;
        handshake(c, 8'($urandom));
        if (c) wait_valid();
        chain++;
      end while (c);
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        out_ready = 1'($urandom);
        @(negedge clk);
      end
      out_ready = 1'b0;
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
